// File: rtl/clk_step_ctrl_pkg.sv
// Shared types for the processor clock-enable controller.
// FSM state encoding is also what the LEDs display.
package clk_step_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_HALT = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/clk_step_ctrl_key_debounce.sv
// Pushbutton synchronizer and debouncer.
// Emits a one-cycle event when a press (1->0) is accepted.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic CLOCK_50,
    input  logic reset,
    input  logic step_key,
    output logic step_evt
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

    logic          key_s1;
    logic          key_s2;
    logic          key_level;
    logic [CW-1:0] stab_cnt;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            key_s1    <= 1'b0;
            key_s2    <= 1'b0;
            key_level <= 1'b1;
            stab_cnt  <= '0;
            step_evt  <= 1'b0;
        end else begin
            key_s1   <= step_key;
            key_s2   <= key_s1;
            step_evt <= 1'b0;
            if (key_s2 == key_level) begin
                stab_cnt <= '0;
            end else if (stab_cnt == CNT_MAX) begin
                // only a press is an event; a release just updates the level
                key_level <= key_s2;
                stab_cnt  <= '0;
                step_evt  <= ~key_s2;
            end else begin
                stab_cnt <= stab_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/clk_step_ctrl.sv
// Turns the divider tap into single-cycle cpu_en pulses on CLOCK_50,
// with free-run, single-step and sticky-halt modes.
module clk_step_ctrl
    import clk_step_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int CNT_W           = 16
) (
    input  logic               CLOCK_50,
    input  logic               reset,
    input  logic               div_tick_src,
    input  logic               run_mode,
    input  logic               step_key,
    input  logic               halt_req,
    output logic               cpu_en,
    output logic [CNT_W-1:0]   cycle_count,
    output logic [STATE_W-1:0] state
);

    state_t st_q;
    state_t st_d;
    logic   en_d;
    logic   tick_s1;
    logic   tick_s2;
    logic   tick_prev;
    logic   div_rise;
    logic   step_evt;

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key (
        .CLOCK_50(CLOCK_50),
        .reset   (reset),
        .step_key(step_key),
        .step_evt(step_evt)
    );

    assign div_rise = tick_s2 & ~tick_prev;
    assign state    = st_q;

    always_comb begin
        st_d = st_q;
        en_d = 1'b0;
        unique case (st_q)
            ST_HALT: begin
                if (halt_req)      st_d = ST_DONE;
                else if (run_mode) st_d = ST_RUN;
                else if (step_evt) st_d = ST_STEP;
            end
            ST_RUN: begin
                if (halt_req)       st_d = ST_DONE;
                else if (!run_mode) st_d = ST_HALT;
                else                en_d = div_rise;
            end
            ST_STEP: begin
                if (halt_req) begin
                    st_d = ST_DONE;
                end else if (div_rise) begin
                    en_d = 1'b1;
                    st_d = ST_HALT;
                end
            end
            ST_DONE: st_d = ST_DONE;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            tick_s1     <= 1'b0;
            tick_s2     <= 1'b0;
            tick_prev   <= 1'b0;
            st_q        <= ST_HALT;
            cpu_en      <= 1'b0;
            cycle_count <= '0;
        end else begin
            tick_s1   <= div_tick_src;
            tick_s2   <= tick_s1;
            tick_prev <= tick_s2;
            st_q      <= st_d;
            cpu_en    <= en_d;
            if (cpu_en) cycle_count <= cycle_count + 1'b1;
        end
    end

endmodule
